// File: rtl/dual_issue_hazard_ctrl_if.sv
// Handshake bundle between the dual-issue ID/EX datapath (master) and its
// hazard controller (slave).
interface dual_issue_hazard_ctrl_if #(
  parameter int RW = 5,
  parameter int CW = 8
);
  logic          id_valid_1, id_valid_2;
  logic [RW-1:0] id_rs1_1, id_rs2_1, id_rs1_2, id_rs2_2;
  logic [RW-1:0] id_rd_1, id_rd_2;
  logic          id_regwrite_1, id_regwrite_2;
  logic          id_memop_1, id_memop_2;
  logic          ex_memread_1, ex_memread_2;
  logic [RW-1:0] ex_rd_1, ex_rd_2;
  logic          branch_flush;
  logic          perf_clr;
  logic          pc_stall;
  logic          bubble_1, bubble_2;
  logic          split_busy;
  logic [CW-1:0] stall_count;

  modport master (
    output id_valid_1, id_valid_2, id_rs1_1, id_rs2_1, id_rs1_2, id_rs2_2,
           id_rd_1, id_rd_2, id_regwrite_1, id_regwrite_2, id_memop_1, id_memop_2,
           ex_memread_1, ex_memread_2, ex_rd_1, ex_rd_2, branch_flush, perf_clr,
    input  pc_stall, bubble_1, bubble_2, split_busy, stall_count
  );

  modport slave (
    input  id_valid_1, id_valid_2, id_rs1_1, id_rs2_1, id_rs1_2, id_rs2_2,
           id_rd_1, id_rd_2, id_regwrite_1, id_regwrite_2, id_memop_1, id_memop_2,
           ex_memread_1, ex_memread_2, ex_rd_1, ex_rd_2, branch_flush, perf_clr,
    output pc_stall, bubble_1, bubble_2, split_busy, stall_count
  );
endinterface

// File: rtl/dual_issue_hazard_ctrl.sv
// Dual-issue ID/EX hazard controller: pair/split issue, load-use hold, flush.
// Optional saturating stall counter is built when HAZARD_PERF_CNT_EN is defined.
module dual_issue_hazard_ctrl #(
  parameter int RW = 5,
  parameter int CW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  dual_issue_hazard_ctrl_if.slave hz
);

  typedef enum logic {PAIR, SECOND} state_e;

  state_e state_q, state_d;
  logic   lu, sp;
  logic   pc_stall, bubble_1, bubble_2;

  // Register 0 is hardwired, so a zero producer index never matches.
  function automatic logic rd_hit(input logic [RW-1:0] rd, input logic [RW-1:0] src);
    return (rd != '0) && (rd == src);
  endfunction

  function automatic logic src_hit(input logic [RW-1:0] rd,
                                   input logic [RW-1:0] rs1,
                                   input logic [RW-1:0] rs2);
    return rd_hit(rd, rs1) || rd_hit(rd, rs2);
  endfunction

  always_comb begin
    logic pend_1, pend_2, raw, waw, strct;
    pend_1 = hz.id_valid_1 && (state_q == PAIR);
    pend_2 = hz.id_valid_2;

    lu = (hz.ex_memread_1 &&
          ((pend_1 && src_hit(hz.ex_rd_1, hz.id_rs1_1, hz.id_rs2_1)) ||
           (pend_2 && src_hit(hz.ex_rd_1, hz.id_rs1_2, hz.id_rs2_2)))) ||
         (hz.ex_memread_2 &&
          ((pend_1 && src_hit(hz.ex_rd_2, hz.id_rs1_1, hz.id_rs2_1)) ||
           (pend_2 && src_hit(hz.ex_rd_2, hz.id_rs1_2, hz.id_rs2_2))));

    raw   = hz.id_regwrite_1 && src_hit(hz.id_rd_1, hz.id_rs1_2, hz.id_rs2_2);
    waw   = hz.id_regwrite_1 && hz.id_regwrite_2 && rd_hit(hz.id_rd_1, hz.id_rd_2);
    strct = hz.id_memop_1 && hz.id_memop_2;
    sp    = (state_q == PAIR) && hz.id_valid_1 && hz.id_valid_2 && (raw || waw || strct);
  end

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    pc_stall = 1'b0;
    bubble_1 = 1'b1;
    bubble_2 = 1'b1;
    if (!reset) begin
      state_d = PAIR;
    end else if (hz.branch_flush) begin
      state_d = PAIR;
    end else begin
      unique case (state_q)
        PAIR: begin
          if (lu) begin
            pc_stall = 1'b1;
          end else if (sp) begin
            bubble_1 = 1'b0;
            pc_stall = 1'b1;
            state_d  = SECOND;
          end else begin
            bubble_1 = !hz.id_valid_1;
            bubble_2 = !hz.id_valid_2;
          end
        end
        SECOND: begin
          if (lu) begin
            pc_stall = 1'b1;
          end else begin
            bubble_2 = 1'b0;
            state_d  = PAIR;
          end
        end
        default: state_d = PAIR;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= PAIR;
    else        state_q <= state_d;
  end

  assign hz.pc_stall   = pc_stall;
  assign hz.bubble_1   = bubble_1;
  assign hz.bubble_2   = bubble_2;
  assign hz.split_busy = reset && (state_q == SECOND);

`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (hz.perf_clr)                    cnt_d = '0;
    else if (pc_stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign hz.stall_count = cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = hz.perf_clr;
  assign hz.stall_count  = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_dual_issue_hazard_ctrl.sv
// Directed bench for dual_issue_hazard_ctrl; stall counter expectations follow
// whether HAZARD_PERF_CNT_EN is defined in the build.
module tb_dual_issue_hazard_ctrl;
  localparam int RW = 5;
  localparam int CW = 8;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic [3:0]    obs;
  logic [CW-1:0] exp_sc;

  dual_issue_hazard_ctrl_if #(.RW(RW), .CW(CW)) hz_if ();
  dual_issue_hazard_ctrl #(.RW(RW), .CW(CW)) dut (.clk(clk), .reset(reset), .hz(hz_if));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz_if.id_valid_1 = 0; hz_if.id_valid_2 = 0;
    hz_if.id_rs1_1 = 0; hz_if.id_rs2_1 = 0; hz_if.id_rs1_2 = 0; hz_if.id_rs2_2 = 0;
    hz_if.id_rd_1 = 0; hz_if.id_rd_2 = 0;
    hz_if.id_regwrite_1 = 0; hz_if.id_regwrite_2 = 0;
    hz_if.id_memop_1 = 0; hz_if.id_memop_2 = 0;
    hz_if.ex_memread_1 = 0; hz_if.ex_memread_2 = 0;
    hz_if.ex_rd_1 = 0; hz_if.ex_rd_2 = 0;
    hz_if.branch_flush = 0; hz_if.perf_clr = 0;
  endtask

  // lane 1: rd=3 rs=1,2 ; lane 2: rd=4 rs=5,6
  task automatic set_indep_pair();
    hz_if.id_valid_1 = 1; hz_if.id_valid_2 = 1;
    hz_if.id_rd_1 = 3; hz_if.id_rs1_1 = 1; hz_if.id_rs2_1 = 2; hz_if.id_regwrite_1 = 1;
    hz_if.id_rd_2 = 4; hz_if.id_rs1_2 = 5; hz_if.id_rs2_2 = 6; hz_if.id_regwrite_2 = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #2;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0110) begin errors++; $display("FAIL reset_outs: {pc,b1,b2,busy} got %b expected 0110", obs); end
    checks++;
    if (hz_if.stall_count !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", hz_if.stall_count); end
    @(negedge clk) reset = 1'b1;
    step();
  endtask

  task automatic test_independent();
    set_indep_pair();
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL indep_c0: {pc,b1,b2,busy} got %b expected 0000", obs); end
    step();
    checks++;
    if (hz_if.split_busy !== 1'b0) begin errors++; $display("FAIL indep_state: busy got %b expected 0", hz_if.split_busy); end
    clear_inputs();
  endtask

  // Drives a pair that must split: checks cycle 0 and the SECOND cycle, then leaves SECOND.
  task automatic run_split(input string name);
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b1010) begin errors++; $display("FAIL %s_c0: {pc,b1,b2,busy} got %b expected 1010", name, obs); end
    step();
    exp_cnt++;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0101) begin errors++; $display("FAIL %s_c1: {pc,b1,b2,busy} got %b expected 0101", name, obs); end
    step();
    clear_inputs();
    #1;
    checks++;
    if (hz_if.split_busy !== 1'b0) begin errors++; $display("FAIL %s_back: busy got %b expected 0", name, hz_if.split_busy); end
  endtask

  task automatic test_raw();
    set_indep_pair();
    hz_if.id_rs1_2 = 3;
    run_split("raw");
    exp_sc = CNT_EN ? CW'(1) : '0;
    checks++;
    if (hz_if.stall_count !== exp_sc) begin errors++; $display("FAIL raw_cnt: got %0d expected %0d", hz_if.stall_count, exp_sc); end
  endtask

  task automatic test_load_use();
    set_indep_pair();
    hz_if.id_rs2_1 = 7;
    hz_if.ex_memread_2 = 1; hz_if.ex_rd_2 = 7;
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL lu_c0: {pc,b1,b2,busy} got %b expected 1110", obs); end
    step();
    exp_cnt++;
    hz_if.ex_memread_2 = 0; hz_if.ex_rd_2 = 0;
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL lu_c1: {pc,b1,b2,busy} got %b expected 0000", obs); end
    hz_if.ex_memread_2 = 1; hz_if.id_rs2_1 = 0;
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL lu_r0: {pc,b1,b2,busy} got %b expected 0000", obs); end
    step();
    clear_inputs();
  endtask

  task automatic test_struct_waw();
    set_indep_pair();
    hz_if.id_memop_1 = 1; hz_if.id_memop_2 = 1;
    run_split("memop");
    set_indep_pair();
    hz_if.id_rd_1 = 5; hz_if.id_rd_2 = 5;
    run_split("waw");
    exp_sc = CNT_EN ? CW'(exp_cnt) : '0;
    checks++;
    if (hz_if.stall_count !== exp_sc) begin errors++; $display("FAIL split_cnt: got %0d expected %0d", hz_if.stall_count, exp_sc); end
  endtask

  task automatic test_boundaries();
    set_indep_pair();
    hz_if.id_rd_1 = 0; hz_if.id_rs1_2 = 0; hz_if.id_rd_2 = 0;
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL r0_nosplit: {pc,b1,b2,busy} got %b expected 0000", obs); end
    set_indep_pair();
    hz_if.id_valid_2 = 0; hz_if.id_memop_1 = 1; hz_if.id_memop_2 = 1; hz_if.id_rs1_2 = 3;
    hz_if.ex_memread_1 = 1; hz_if.ex_rd_1 = 5;
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0010) begin errors++; $display("FAIL invalid_lane: {pc,b1,b2,busy} got %b expected 0010", obs); end
    step();
    clear_inputs();
  endtask

  task automatic test_load_then_dep();
    hz_if.id_valid_1 = 1; hz_if.id_valid_2 = 1;
    hz_if.id_rd_1 = 3; hz_if.id_rs1_1 = 1; hz_if.id_regwrite_1 = 1; hz_if.id_memop_1 = 1;
    hz_if.id_rd_2 = 4; hz_if.id_rs1_2 = 3; hz_if.id_rs2_2 = 2; hz_if.id_regwrite_2 = 1;
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b1010) begin errors++; $display("FAIL ldep_c0: {pc,b1,b2,busy} got %b expected 1010", obs); end
    step();
    exp_cnt++;
    hz_if.ex_memread_1 = 1; hz_if.ex_rd_1 = 3;
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b1111) begin errors++; $display("FAIL ldep_c1: {pc,b1,b2,busy} got %b expected 1111", obs); end
    step();
    exp_cnt++;
    hz_if.ex_memread_1 = 0; hz_if.ex_rd_1 = 0;
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0101) begin errors++; $display("FAIL ldep_c2: {pc,b1,b2,busy} got %b expected 0101", obs); end
    step();
    clear_inputs();
    #1;
    exp_sc = CNT_EN ? CW'(exp_cnt) : '0;
    checks++;
    if (hz_if.stall_count !== exp_sc) begin errors++; $display("FAIL ldep_cnt: got %0d expected %0d", hz_if.stall_count, exp_sc); end
  endtask

  task automatic test_flush();
    set_indep_pair();
    hz_if.id_rs1_2 = 3;
    step();
    exp_cnt++;
    hz_if.ex_memread_2 = 1; hz_if.ex_rd_2 = 3; hz_if.branch_flush = 1;
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0111) begin errors++; $display("FAIL flush_second: {pc,b1,b2,busy} got %b expected 0111", obs); end
    step();
    checks++;
    if (hz_if.split_busy !== 1'b0) begin errors++; $display("FAIL flush_state: busy got %b expected 0", hz_if.split_busy); end
    clear_inputs();
    set_indep_pair();
    hz_if.ex_memread_1 = 1; hz_if.ex_rd_1 = 1; hz_if.branch_flush = 1;
    #1;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0110) begin errors++; $display("FAIL flush_lu: {pc,b1,b2,busy} got %b expected 0110", obs); end
    step();
    clear_inputs();
    exp_sc = CNT_EN ? CW'(exp_cnt) : '0;
    checks++;
    if (hz_if.stall_count !== exp_sc) begin errors++; $display("FAIL flush_cnt: got %0d expected %0d", hz_if.stall_count, exp_sc); end
  endtask

  task automatic test_reset_mid_split();
    set_indep_pair();
    hz_if.id_rs2_2 = 3;
    step();
    checks++;
    if (hz_if.split_busy !== 1'b1) begin errors++; $display("FAIL mid_enter: busy got %b expected 1", hz_if.split_busy); end
    reset = 1'b0;
    #1;
    exp_cnt = 0;
    obs = {hz_if.pc_stall, hz_if.bubble_1, hz_if.bubble_2, hz_if.split_busy};
    checks++;
    if (obs !== 4'b0110) begin errors++; $display("FAIL mid_reset: {pc,b1,b2,busy} got %b expected 0110", obs); end
    checks++;
    if (hz_if.stall_count !== 8'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d expected 0", hz_if.stall_count); end
    clear_inputs();
    @(negedge clk) reset = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    hz_if.id_valid_1 = 1; hz_if.id_rs1_1 = 2;
    hz_if.ex_memread_1 = 1; hz_if.ex_rd_1 = 2;
    for (int i = 0; i < 300; i++) step();
    exp_sc = CNT_EN ? 8'd255 : 8'd0;
    checks++;
    if (hz_if.stall_count !== exp_sc) begin errors++; $display("FAIL sat_cnt: got %0d expected %0d", hz_if.stall_count, exp_sc); end
    checks++;
    if (hz_if.pc_stall !== 1'b1) begin errors++; $display("FAIL sat_stall: pc_stall got %b expected 1", hz_if.pc_stall); end
    hz_if.perf_clr = 1;
    step();
    checks++;
    if (hz_if.stall_count !== 8'd0) begin errors++; $display("FAIL perf_clr: got %0d expected 0", hz_if.stall_count); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_load_use();
    test_struct_waw();
    test_boundaries();
    test_load_then_dep();
    test_flush();
    test_reset_mid_split();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
